// File: rtl/vending_pkg.sv
// ============================================================================
// Module      : vending_pkg
// Description : Shared constants, dispenser state encoding and tens clamp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vending_pkg;

   localparam logic [9:0] DROP_TEN  = 10'h3FF;
   localparam logic [9:0] DROP_FIVE = 10'b1111100000;
   localparam logic [9:0] DROP_NONE = 10'h000;
   localparam logic [3:0] MAX_TENS  = 4'd9;

   typedef enum logic [1:0] {
      DISP_IDLE = 2'd0,
      DISP_DROP = 2'd1,
      DISP_GAP  = 2'd2,
      DISP_DONE = 2'd3
   } disp_state_e;

   function automatic logic [3:0] clamp_tens(input logic [3:0] tens);
      return (tens > MAX_TENS) ? MAX_TENS : tens;
   endfunction

endpackage

`default_nettype wire

// File: rtl/change_dispenser_if.sv
// ============================================================================
// Module      : change_dispenser_if
// Description : Request handshake and payout status between controller and
//               change dispenser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface change_dispenser_if;
   logic       req_valid;
   logic [3:0] req_tens;
   logic       req_five;
   logic       req_ready;
   logic [9:0] drop_money;
   logic       busy;
   logic       done;
   logic [3:0] remain_tens;
   logic       remain_five;

   modport master (
      output req_valid, req_tens, req_five,
      input  req_ready, drop_money, busy, done, remain_tens, remain_five
   );

   modport slave (
      input  req_valid, req_tens, req_five,
      output req_ready, drop_money, busy, done, remain_tens, remain_five
   );
endinterface

`default_nettype wire

// File: rtl/change_dispenser_tick_gen.sv
// ============================================================================
// Module      : tick_gen
// Description : Prescaler; tick is high on the last cycle of each TICK_DIV
//               period. Synchronous clear restarts the period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
   parameter int TICK_DIV = 67108864
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_clear,
   output logic      o_tick
);

   localparam int                c_CW   = $clog2(TICK_DIV);
   localparam logic [c_CW-1:0]   c_LAST = c_CW'(TICK_DIV - 1);

   logic [c_CW-1:0] r_count;

   assign o_tick = (r_count == c_LAST);

   always_ff @(posedge clk) begin
      if (rst || i_clear || o_tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================================
// Module      : change_dispenser
// Description : Pays out a tens/five change amount one coin per tick period.
//               Define CHANGE_DISPENSE_GAP_EN to insert dark gaps between coins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module change_dispenser
   import vending_pkg::*;
#(
   parameter int TICK_DIV = 67108864
) (
   input  wire logic          clk,
   input  wire logic          rst,
   change_dispenser_if.slave  bus
);

   localparam logic [1:0] c_ST_IDLE = DISP_IDLE;
   localparam logic [1:0] c_ST_DROP = DISP_DROP;
   localparam logic [1:0] c_ST_DONE = DISP_DONE;
`ifdef CHANGE_DISPENSE_GAP_EN
   localparam logic [1:0] c_ST_GAP  = DISP_GAP;
`endif

   logic [1:0] r_state;
   logic [3:0] r_tens;
   logic       r_five;
   logic [9:0] r_drop;
   logic       r_busy;
   logic       r_done;
   logic       r_ready;

   logic       w_tick;
   logic       w_clear;
   logic       w_accept;
   logic       w_more;
   logic [3:0] w_req_tens;
   logic [9:0] w_next_drop;
   logic [3:0] w_next_tens;
   logic       w_next_five;

   assign w_accept   = bus.req_valid && r_ready;
   assign w_req_tens = clamp_tens(bus.req_tens);
   assign w_more     = (r_tens != 4'd0) || r_five;
   // The prescaler only runs while a coin or gap is being timed.
   assign w_clear    = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE);

   always_comb begin
      w_next_drop = DROP_FIVE;
      w_next_tens = r_tens;
      w_next_five = 1'b0;
      if (r_tens != 4'd0) begin
         w_next_drop = DROP_TEN;
         w_next_tens = r_tens - 4'd1;
         w_next_five = r_five;
      end
   end

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .i_clear (w_clear),
      .o_tick  (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_ST_IDLE;
         r_tens  <= 4'd0;
         r_five  <= 1'b0;
         r_drop  <= DROP_NONE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (w_accept) begin
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  if (w_req_tens != 4'd0) begin
                     r_tens  <= w_req_tens - 4'd1;
                     r_five  <= bus.req_five;
                     r_drop  <= DROP_TEN;
                     r_state <= c_ST_DROP;
                  end else if (bus.req_five) begin
                     r_tens  <= 4'd0;
                     r_five  <= 1'b0;
                     r_drop  <= DROP_FIVE;
                     r_state <= c_ST_DROP;
                  end else begin
                     r_tens  <= 4'd0;
                     r_five  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= c_ST_DONE;
                  end
               end
            end

            c_ST_DROP: begin
               if (w_tick) begin
                  if (!w_more) begin
                     r_drop  <= DROP_NONE;
                     r_done  <= 1'b1;
                     r_state <= c_ST_DONE;
                  end else begin
`ifdef CHANGE_DISPENSE_GAP_EN
                     r_drop  <= DROP_NONE;
                     r_state <= c_ST_GAP;
`else
                     // Contiguous coins: same pattern reloads with no dark cycle.
                     r_drop  <= w_next_drop;
                     r_tens  <= w_next_tens;
                     r_five  <= w_next_five;
`endif
                  end
               end
            end

`ifdef CHANGE_DISPENSE_GAP_EN
            c_ST_GAP: begin
               if (w_tick) begin
                  r_drop  <= w_next_drop;
                  r_tens  <= w_next_tens;
                  r_five  <= w_next_five;
                  r_state <= c_ST_DROP;
               end
            end
`endif

            c_ST_DONE: begin
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= c_ST_IDLE;
            end

            default: begin
               r_drop  <= DROP_NONE;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready   = r_ready;
   assign bus.drop_money  = r_drop;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.remain_tens = r_tens;
   assign bus.remain_five = r_five;

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ============================================================================
// Module      : tb_change_dispenser
// Description : Directed scoreboard bench for change_dispenser at TICK_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_change_dispenser;

   localparam int         c_TD   = 4;
   localparam logic [9:0] c_TEN  = 10'h3FF;
   localparam logic [9:0] c_FIVE = 10'h3E0;

   typedef struct packed {
      logic [9:0] drop;
      logic [3:0] rt;
      logic       rf;
      logic       busy;
      logic       done;
      logic       ready;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   change_dispenser_if bus ();

   change_dispenser #(
      .TICK_DIV (c_TD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_rec(input exp_t e, input int k);
      string s;
      s = $sformatf("c%0d", k);
      check({"drop_money@", s},  bus.drop_money,          e.drop);
      check({"remain_tens@", s}, {6'd0, bus.remain_tens}, {6'd0, e.rt});
      check({"remain_five@", s}, {9'd0, bus.remain_five}, {9'd0, e.rf});
      check({"busy@", s},        {9'd0, bus.busy},        {9'd0, e.busy});
      check({"done@", s},        {9'd0, bus.done},        {9'd0, e.done});
      check({"req_ready@", s},   {9'd0, bus.req_ready},   {9'd0, e.ready});
   endtask

   function automatic exp_t idle_rec();
      return '{drop: 10'd0, rt: 4'd0, rf: 1'b0, busy: 1'b0, done: 1'b0, ready: 1'b1};
   endfunction

   // Reference model: expected per-cycle outputs from T+1 until back in idle.
   task automatic push_expect(input logic [3:0] tens, input logic five);
      int nt;
      int nc;
      exp_t e;
      nt = (tens > 4'd9) ? 9 : int'(tens);
      nc = nt + int'(five);
      for (int i = 0; i < nc; i++) begin
         if (i < nt) begin
            e = '{drop: c_TEN, rt: 4'(nt - 1 - i), rf: five, busy: 1'b1, done: 1'b0, ready: 1'b0};
         end else begin
            e = '{drop: c_FIVE, rt: 4'd0, rf: 1'b0, busy: 1'b1, done: 1'b0, ready: 1'b0};
         end
         for (int j = 0; j < c_TD; j++) q.push_back(e);
`ifdef CHANGE_DISPENSE_GAP_EN
         if (i < nc - 1) begin
            e.drop = 10'd0;
            for (int j = 0; j < c_TD; j++) q.push_back(e);
         end
`endif
      end
      q.push_back('{drop: 10'd0, rt: 4'd0, rf: 1'b0, busy: 1'b1, done: 1'b1, ready: 1'b0});
      q.push_back(idle_rec());
   endtask

   task automatic run_req(input logic [3:0] tens, input logic five,
                          input int abort_k, input bit ghost);
      int   k;
      exp_t e;
      push_expect(tens, five);
      bus.req_valid = 1'b1;
      bus.req_tens  = tens;
      bus.req_five  = five;
      step();
      bus.req_valid = 1'b0;
      k = 1;
      while (q.size() > 0) begin
         e = q.pop_front();
         check_rec(e, k);
         if (ghost && k == 6) begin
            bus.req_valid = 1'b1;
            bus.req_tens  = 4'd5;
            bus.req_five  = 1'b1;
         end
         if (ghost && k == 20) bus.req_valid = 1'b0;
         if (abort_k != 0 && k == abort_k + 1) rst = 1'b0;
         if (abort_k != 0 && k == abort_k) begin
            rst = 1'b1;
            q.delete();
            for (int j = 0; j < 3; j++) q.push_back(idle_rec());
         end
         step();
         k++;
      end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_tens  = 4'd0;
      bus.req_five  = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      check_rec(idle_rec(), 0);
      step();
      check_rec(idle_rec(), 0);

      run_req(4'd2,  1'b1, 0, 1'b0);
      run_req(4'd0,  1'b0, 0, 1'b0);
      run_req(4'd0,  1'b1, 0, 1'b0);
      run_req(4'd12, 1'b0, 0, 1'b1);
      run_req(4'd3,  1'b0, 6, 1'b0);
      run_req(4'd1,  1'b0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/change_dispenser.md
# change_dispenser

Downstream of the vending-machine controller. Takes a change amount (tens count plus an optional five) through a valid/ready handshake and pays it out one coin at a time, paced by a slow tick. Each coin is shown on the `drop_money` LED bar for one tick period. The controller hands over the change, waits for `done`, then returns to its initial state.

## Interface
- `TICK_DIV`, default 67108864: clk cycles each coin (or gap) is held; must be ≥2.
- `clk` input 1: system clock.
- `rst` input 1: reset. Synchronous and active-high.
- `req_valid` input 1: a change request is present.
- `req_tens` input 4: number of 10-coins. Binary; values >9 are clamped to 9 at accept.
- `req_five` input 1: one 5-coin follows the tens.
- `req_ready` output 1: block is idle and can accept a request.
- `drop_money` output 10: LED pattern. `10'h3FF` = ten, `10'b1111100000` = five, `0` = none.
- `busy` output 1: a request is being paid out.
- `done` output 1: one-cycle pulse when payout is complete.
- `remain_tens` output 4: tens not yet started (for the display).
- `remain_five` output 1: five not yet started.

## Operation
- States: IDLE, DROP, GAP (only when the macro is defined), DONE.
- IDLE
  - `req_ready`=1, `busy`=0, `drop_money`=0.
  - Accept happens on a cycle with `req_valid && req_ready`.
  - On accept, latch the clamped tens and the five.
  - If the amount is nonzero, go to DROP. If it is zero, go to DONE.
- Coin order: all tens first, then the five.
- Entering DROP
  - Select the next coin.
  - Decrement `remain_tens`, or clear `remain_five`, in the same cycle `drop_money` shows that coin.
  - Restart the tick counter.
- Leaving DROP
  - DROP lasts exactly `TICK_DIV` cycles.
  - If coins remain: go to GAP when the macro is defined, otherwise straight to the next DROP.
  - If no coins remain: go to DONE.
- GAP: `drop_money`=0 for `TICK_DIV` cycles, then DROP.
- DONE: lasts one cycle.
  - `done`=1, `drop_money`=0, `req_ready`=0.
  - Then IDLE.
- `busy`=1 in DROP, GAP and DONE.
- `req_valid` is ignored while `req_ready`=0. No queueing: a request presented while busy must be held by the sender.
- Reset values: state IDLE, tick counter 0, `drop_money`=0, `busy`=0, `done`=0, `remain_tens`=0, `remain_five`=0, `req_ready`=1 from the first cycle after reset.
- Reset mid-payout: abort immediately. No `done` pulse. Remaining coins are discarded.

## Timing
- All outputs are registered. Accept is on cycle T.
- First coin is visible at T+1.
- Without the macro: N coins occupy T+1 .. T+N·TICK_DIV. `done` is at T+N·TICK_DIV+1. `req_ready` is 1 at T+N·TICK_DIV+2.
- With the macro: add (N−1)·TICK_DIV gap cycles before `done`. There is no gap after the last coin.
- Zero request: `done` at T+1, `req_ready` at T+2, `drop_money` never nonzero.
- Back-to-back consecutive coins with no gap: `drop_money` stays constant across the boundary.
- Tick counter width is $clog2(TICK_DIV). Wraps to 0 at TICK_DIV−1 and on every state entry.

## Configuration
- `CHANGE_DISPENSE_GAP_EN`
  - Defined: GAP state exists. Every coin is separated by `TICK_DIV` cycles of dark LEDs, so consecutive tens are visibly distinct.
  - Undefined: GAP state is not compiled in. Coins are contiguous.

## Structure
- Shared package `vending_pkg` holds:
  - the `DROP_TEN`, `DROP_FIVE` and `DROP_NONE` 10-bit constants;
  - the dispenser state enum;
  - the `MAX_TENS`=9 constant.
- One sub-module, `tick_gen`: parameterised prescaler with synchronous clear. Outputs `tick` on the last cycle of each `TICK_DIV` period.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then idle: `req_ready`=1, all other outputs 0.
- Request `req_tens`=2, `req_five`=1, no macro:
  - ten at T+1..4 and T+5..8; five at T+9..12;
  - `done` at T+13;
  - `remain_tens` goes 1 at T+1, 0 at T+5; `remain_five` goes 0 at T+9.
- Same request with the macro:
  - ten at T+1..4, gap at 5..8, ten at 9..12, gap at 13..16, five at 17..20;
  - `done` at T+21.
- Zero request: `done` at T+1, `drop_money` stays 0, `req_ready` back at T+2.
- `req_tens`=12: clamped, exactly 9 tens paid out. A second `req_valid` asserted mid-payout is ignored.
- `rst` asserted at T+6 of a 3-ten request: next cycle shows IDLE with all outputs at reset values and no `done` pulse.
